// File: rtl/gen_reg_file.sv
// gen_reg_file: parametrised register file with byte-masked write port,
// two registered read ports with write-first forwarding and a busy scoreboard.
module gen_reg_file #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 16,
    parameter int ZERO_R0 = 1,
    localparam int AW     = $clog2(DEPTH),
    localparam int NB     = WIDTH / 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wr,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] bus,
    input  logic [NB-1:0]    be,
    input  logic             rd_a_en,
    input  logic [AW-1:0]    ra_a,
    output logic [WIDTH-1:0] out_a,
    input  logic             rd_b_en,
    input  logic [AW-1:0]    ra_b,
    output logic [WIDTH-1:0] out_b,
    input  logic             rsv,
    input  logic [AW-1:0]    rsv_addr,
    output logic             busy_a,
    output logic             busy_b,
    output logic             err
);

    localparam bit Z = (ZERO_R0 != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic             wr_ok;
    logic             rsv_ok;
    logic             dbl_rsv;

    assign wr_ok  = wr && !(Z && waddr == '0);
    assign rsv_ok = rsv && !(Z && rsv_addr == '0);

    always_comb begin
        merged = mem[waddr];
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = bus[8*i +: 8];
            end
        end
    end

    // Read data reflects this edge's write (write-first).
    always_comb begin
        rdata_a = mem[ra_a];
        if (Z && ra_a == '0) begin
            rdata_a = '0;
        end else if (wr_ok && waddr == ra_a) begin
            rdata_a = merged;
        end
    end

    always_comb begin
        rdata_b = mem[ra_b];
        if (Z && ra_b == '0) begin
            rdata_b = '0;
        end else if (wr_ok && waddr == ra_b) begin
            rdata_b = merged;
        end
    end

    // A same-edge write releases the old producer, so re-reserving is legal.
    assign dbl_rsv = rsv_ok && busy[rsv_addr]
                     && !(wr_ok && waddr == rsv_addr);

    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[waddr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy  <= '0;
            out_a <= '0;
            out_b <= '0;
            err   <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[waddr] <= merged;
            end
            if (rd_a_en) begin
                out_a <= rdata_a;
            end
            if (rd_b_en) begin
                out_b <= rdata_b;
            end
            busy <= busy_nxt;
            if (dbl_rsv) begin
                err <= 1'b1;
            end
        end
    end

    assign busy_a = busy[ra_a] && !(Z && ra_a == '0);
    assign busy_b = busy[ra_b] && !(Z && ra_b == '0);

endmodule

// File: tb/tb_gen_reg_file.sv
// tb_gen_reg_file: directed vectors, expectations queued at issue time and
// compared by an independent monitor after each rising edge.
module tb_gen_reg_file;

    localparam int OA  = 0;
    localparam int OB  = 1;
    localparam int BA  = 2;
    localparam int BB  = 3;
    localparam int ER  = 4;
    localparam int ZA  = 5;
    localparam int ZBA = 6;
    localparam int ZER = 7;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk;
    logic        clr;
    logic        wr;
    logic [3:0]  waddr;
    logic [31:0] bus;
    logic [3:0]  be;
    logic        rd_a_en;
    logic [3:0]  ra_a;
    logic        rd_b_en;
    logic [3:0]  ra_b;
    logic        rsv;
    logic [3:0]  rsv_addr;

    logic [31:0] out_a;
    logic [31:0] out_b;
    logic        busy_a;
    logic        busy_b;
    logic        err;
    logic [31:0] z_out_a;
    logic [31:0] z_out_b;
    logic        z_busy_a;
    logic        z_busy_b;
    logic        z_err;

    exp_t q[$];
    int   cyc;
    int   checks;
    int   errors;

    gen_reg_file #(.WIDTH(32), .DEPTH(16), .ZERO_R0(1)) dut (
        .clk(clk), .clr(clr), .wr(wr), .waddr(waddr), .bus(bus), .be(be),
        .rd_a_en(rd_a_en), .ra_a(ra_a), .out_a(out_a),
        .rd_b_en(rd_b_en), .ra_b(ra_b), .out_b(out_b),
        .rsv(rsv), .rsv_addr(rsv_addr),
        .busy_a(busy_a), .busy_b(busy_b), .err(err)
    );

    gen_reg_file #(.WIDTH(32), .DEPTH(16), .ZERO_R0(0)) dut_nz (
        .clk(clk), .clr(clr), .wr(wr), .waddr(waddr), .bus(bus), .be(be),
        .rd_a_en(rd_a_en), .ra_a(ra_a), .out_a(z_out_a),
        .rd_b_en(rd_b_en), .ra_b(ra_b), .out_b(z_out_b),
        .rsv(rsv), .rsv_addr(rsv_addr),
        .busy_a(z_busy_a), .busy_b(z_busy_b), .err(z_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] actual(input int sig);
        case (sig)
            OA:      return out_a;
            OB:      return out_b;
            BA:      return {31'b0, busy_a};
            BB:      return {31'b0, busy_b};
            ER:      return {31'b0, err};
            ZA:      return z_out_a;
            ZBA:     return {31'b0, z_busy_a};
            default: return {31'b0, z_err};
        endcase
    endfunction

    // Monitor: after each edge, compare everything due this cycle.
    initial begin
        cyc = 0;
        checks = 0;
        errors = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t e;
                logic [31:0] a;
                e = q.pop_front();
                a = actual(e.sig);
                checks++;
                if (a !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc %0d: got %h expected %h",
                             e.name, cyc, a, e.val);
                end
            end
        end
    end

    task automatic expect_v(input int sig, input logic [31:0] v,
                            input string name);
        exp_t e;
        e.cyc  = cyc + 1;
        e.sig  = sig;
        e.val  = v;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic idle();
        clr = 0; wr = 0; waddr = 0; bus = 0; be = 0;
        rd_a_en = 0; ra_a = 0; rd_b_en = 0; ra_b = 0;
        rsv = 0; rsv_addr = 0;
    endtask

    initial begin
        idle();
        clr = 1;
        expect_v(OA, 32'h0, "rst_out_a");
        expect_v(OB, 32'h0, "rst_out_b");
        expect_v(BA, 32'h0, "rst_busy_a");
        expect_v(BB, 32'h0, "rst_busy_b");
        expect_v(ER, 32'h0, "rst_err");

        @(negedge clk); idle();
        wr = 1; waddr = 3; bus = 32'hDEADBEEF; be = 4'hF;
        expect_v(OA, 32'h0, "pre_read_out_a");

        @(negedge clk); idle();
        rd_a_en = 1; ra_a = 3;
        expect_v(OA, 32'hDEADBEEF, "basic_read");
        expect_v(ZA, 32'hDEADBEEF, "basic_read_nz");

        @(negedge clk); idle();
        wr = 1; waddr = 5; bus = 32'h11223344; be = 4'hF;

        @(negedge clk); idle();
        wr = 1; waddr = 5; bus = 32'hAABBCCDD; be = 4'b0101;
        rd_a_en = 1; ra_a = 5; rd_b_en = 1; ra_b = 5;
        expect_v(OA, 32'h11BB33DD, "mask_fwd_a");
        expect_v(OB, 32'h11BB33DD, "mask_fwd_b");
        expect_v(ZA, 32'h11BB33DD, "mask_fwd_nz");

        @(negedge clk); idle();
        wr = 1; waddr = 0; bus = 32'hFFFFFFFF; be = 4'hF;
        rsv = 1; rsv_addr = 0;

        @(negedge clk); idle();
        rd_a_en = 1; ra_a = 0;
        expect_v(OA, 32'h0, "r0_read");
        expect_v(BA, 32'h0, "r0_busy");
        expect_v(ER, 32'h0, "r0_err");
        expect_v(ZA, 32'hFFFFFFFF, "nz_r0_read");
        expect_v(ZBA, 32'h1, "nz_r0_busy");
        expect_v(ZER, 32'h0, "nz_r0_err");

        @(negedge clk); idle();
        rsv = 1; rsv_addr = 7; ra_a = 7;
        expect_v(BA, 32'h1, "rsv7_busy");

        @(negedge clk); idle();
        wr = 1; waddr = 7; bus = 32'h77; be = 4'hF; ra_a = 7;
        expect_v(BA, 32'h0, "wr7_release");

        @(negedge clk); idle();
        rsv = 1; rsv_addr = 7; wr = 1; waddr = 7; be = 4'hF; ra_a = 7;
        expect_v(BA, 32'h1, "rsv_wr7_busy");

        @(negedge clk); idle();
        rsv = 1; rsv_addr = 7; wr = 1; waddr = 7; be = 4'hF; ra_a = 7;
        expect_v(BA, 32'h1, "replace7_busy");
        expect_v(ER, 32'h0, "replace7_err");

        @(negedge clk); idle();
        rsv = 1; rsv_addr = 9; ra_b = 9;
        expect_v(BB, 32'h1, "rsv9_busy");
        expect_v(ER, 32'h0, "rsv9_err");

        @(negedge clk); idle();
        rsv = 1; rsv_addr = 9; ra_b = 9;
        expect_v(BB, 32'h1, "dbl9_busy");
        expect_v(ER, 32'h1, "dbl9_err");

        @(negedge clk); idle();
        wr = 1; waddr = 9; bus = 32'h99; be = 4'hF; ra_b = 9;
        expect_v(BB, 32'h0, "wr9_release");
        expect_v(ER, 32'h1, "err_sticky");

        @(negedge clk); idle();
        rsv = 1; rsv_addr = 5; ra_b = 5;
        expect_v(BB, 32'h1, "rsv5_busy");

        @(negedge clk); idle();
        wr = 1; waddr = 5; bus = 32'h0; be = 4'h0;
        rd_b_en = 1; ra_b = 5;
        expect_v(BB, 32'h0, "be0_release");
        expect_v(OB, 32'h11BB33DD, "be0_keeps_data");

        @(negedge clk); idle();
        wr = 1; waddr = 2; bus = 32'h1234; be = 4'hF;
        rd_a_en = 1; ra_a = 2;
        expect_v(OA, 32'h1234, "fwd_1234");

        @(negedge clk); idle();
        wr = 1; waddr = 2; bus = 32'hFFFF; be = 4'hF; ra_a = 2;
        expect_v(OA, 32'h1234, "hold_1");

        @(negedge clk); idle();
        wr = 1; waddr = 2; bus = 32'h5555; be = 4'hF; ra_a = 2;
        expect_v(OA, 32'h1234, "hold_2");
        expect_v(ER, 32'h1, "err_still_set");

        @(negedge clk); idle();
        clr = 1; wr = 1; waddr = 2; bus = 32'hAAAA; be = 4'hF;
        rsv = 1; rsv_addr = 4; rd_a_en = 1; ra_a = 2;
        rd_b_en = 1; ra_b = 4;
        expect_v(OA, 32'h0, "clr_out_a");
        expect_v(OB, 32'h0, "clr_out_b");
        expect_v(BA, 32'h0, "clr_busy_a");
        expect_v(BB, 32'h0, "clr_busy_b");
        expect_v(ER, 32'h0, "clr_err");

        @(negedge clk); idle();
        rd_a_en = 1; ra_a = 2; rd_b_en = 1; ra_b = 3;
        expect_v(OA, 32'h0, "clr_reg2");
        expect_v(OB, 32'h0, "clr_reg3");
        expect_v(ZA, 32'h0, "clr_reg2_nz");

        @(negedge clk); idle();
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gen_reg_file.md
# gen_reg_file

Parametrised general-purpose register file replacing the per-register bank of single 32-bit write-enabled registers in the datapath. It provides one byte-maskable write port from the bus, two registered read ports with same-cycle write forwarding, and a per-register busy scoreboard that the control unit uses to detect read-after-write hazards on multi-cycle operations. An optional hard-wired-zero R0 mode supports the RISC register convention.

## Interface
- WIDTH, 32, data width in bits; must be a multiple of 8
- DEPTH, 16, number of registers; must be a power of 2, ≥2; AW = log2(DEPTH)
- ZERO_R0, 1, when 1 register 0 always reads 0, ignores writes and ignores reservations

Ports:
- clk  in  1  clock; all state changes on rising edge
- clr  in  1  synchronous, active-high reset; sampled on rising edge of clk
- wr  in  1  write strobe
- waddr  in  AW  write register index
- bus  in  WIDTH  write data
- be  in  WIDTH/8  byte-lane write enables; bit i covers bus[8i+7:8i]
- rd_a_en  in  1  read enable, port A
- ra_a  in  AW  read index, port A
- out_a  out  WIDTH  registered read data, port A
- rd_b_en  in  1  read enable, port B
- ra_b  in  AW  read index, port B
- out_b  out  WIDTH  registered read data, port B
- rsv  in  1  reserve request: mark rsv_addr busy (pending producer)
- rsv_addr  in  AW  register index to reserve
- busy_a  out  1  combinational: busy bit of ra_a
- busy_b  out  1  combinational: busy bit of ra_b
- err  out  1  sticky: reservation of an already-busy register

## Operation
- clr high at an edge: all registers, out_a, out_b, all busy bits and err → 0. clr overrides every other input that cycle.
- Write: at an edge with wr=1, update each byte lane i of reg[waddr] where be[i]=1. Other lanes keep their value. be=0 leaves data unchanged. This is not an error.
- The write clears busy[waddr], even when be=0.
- ZERO_R0=1 and waddr=0: data is discarded; busy[0] stays 0.
- Read: at an edge with rd_x_en=1, out_x ← value of reg[ra_x] after this edge's write. Same-cycle write to the same index is forwarded per byte lane (write-first).
- rd_x_en=0: out_x holds its value.
- ZERO_R0=1 and ra_x=0: out_x ← 0.
- Both ports may read the same index; each gets identical data.
- Reserve: at an edge with rsv=1, busy[rsv_addr] ← 1.
- Same edge, rsv and wr to the same index: reservation wins and busy stays 1. This models a new producer replacing the old one. err is not set, because the old reservation is being released.
- rsv to an index already busy with no same-edge wr release to it: err ← 1. busy stays 1. err clears only on clr.
- ZERO_R0=1 and rsv_addr=0: ignored, and err is not set.
- busy_a/busy_b: pure lookup of current busy state for ra_a/ra_b. No forwarding of same-cycle rsv or wr.
- ZERO_R0=1: busy for index 0 always reads 0.

## Timing
- Read latency: 1 cycle. Address/enable are sampled at edge N; data is valid on out_x after edge N.
- Write-to-read: 0 extra cycles. A write and a read of the same index at edge N yield the new data after edge N.
- Reserve-to-busy: rsv at edge N → busy_x high after edge N while ra_x points at it.
- Release: wr at edge N → busy low after edge N.
- Reset values: out_a=0, out_b=0, err=0, busy_a=0, busy_b=0, all registers 0.
- clr asserted mid-sequence discards any pending same-edge write, read or reserve. State is all-zero after that edge.
- No internal multi-cycle state beyond registers, outputs, busy and err. Every operation completes at a single edge.

## Test plan
- Reset/basic write-read: clr, then wr waddr=3 bus=0xDEADBEEF be=0xF; next cycle rd_a_en ra_a=3 → out_a=0xDEADBEEF one cycle later. Before the write, out_a=0.
- Byte mask + forwarding: reg5=0x11223344. At the same edge: wr waddr=5 bus=0xAABBCCDD be=0b0101, rd_a_en and rd_b_en with ra_a=ra_b=5 → out_a=out_b=0x11BB33DD.
- Zero register (ZERO_R0=1): wr waddr=0 bus=0xFFFFFFFF be=0xF, rsv rsv_addr=0, read ra_a=0 → out_a=0, busy_a=0, err=0. With ZERO_R0=0 the same sequence gives out_a=0xFFFFFFFF.
- Scoreboard: rsv rsv_addr=7 → busy_a=1 for ra_a=7. Then wr waddr=7 → busy_a=0 the next cycle. Next, rsv and wr to 7 at the same edge → busy_a stays 1 and err=0.
- Double reservation: rsv 9, then rsv 9 again with no write → err=1 and busy stays 1. err persists through later writes and clears only on clr.
- Hold/clr mid-operation: out_a=0x1234, then rd_a_en=0 with writes to ra_a → out_a stays 0x1234. Then clr together with wr and rsv → all outputs 0 next cycle, and the targeted register reads 0.
